// File: rtl/lfsr_seq_arbiter.sv
// lfsr_seq_arbiter: round-robin shares one external LFSR step unit between two requesters,
// optionally reseeding it and streaming COUNT consecutive states per grant on valid/ready.
module lfsr_seq_arbiter #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [2*CNT_W-1:0]  req_count,
    input  logic [2*DATA_W-1:0] req_seed,
    input  logic [1:0]          req_seed_en,
    output logic [1:0]          ack,
    output logic                lfsr_load,
    output logic [DATA_W-1:0]   lfsr_seed,
    output logic                lfsr_step,
    input  logic [DATA_W-1:0]   lfsr_q,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_id,
    output logic                out_last,
    output logic                busy
);
    typedef enum logic [2:0] {IDLE, LOAD, STEP, CAPT, WAIT, DONE} state_t;
    state_t              state_q, state_d;
    logic                id_q, id_d, prio_q, prio_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_sel;
    logic [DATA_W-1:0]   seed_q, seed_d, data_q, data_d;
    logic                valid_q, valid_d, last_q, last_d;
    logic                load_q, load_d, step_q, step_d, busy_q, busy_d;
    logic [1:0]          ack_q, ack_d;
    logic                gnt;
    // prio_q is the requester that wins when both ask at once
    always_comb begin
        gnt     = (req[0] & req[1]) ? prio_q : req[1];
        cnt_sel = gnt ? req_count[2*CNT_W-1:CNT_W] : req_count[CNT_W-1:0];
        state_d = state_q;
        id_d    = id_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        load_d  = 1'b0;
        step_d  = 1'b0;
        ack_d   = 2'b00;
        case (state_q)
            IDLE: if (|req) begin
                id_d    = gnt;
                cnt_d   = cnt_sel;
                seed_d  = gnt ? req_seed[2*DATA_W-1:DATA_W] : req_seed[DATA_W-1:0];
                state_d = (cnt_sel == '0) ? DONE : (req_seed_en[gnt] ? LOAD : STEP);
                ack_d   = (cnt_sel == '0) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
                load_d  = (cnt_sel != '0) && req_seed_en[gnt];
                step_d  = (cnt_sel != '0) && !req_seed_en[gnt];
            end
            LOAD: begin
                state_d = STEP;
                step_d  = 1'b1;
            end
            STEP: state_d = CAPT;
            CAPT: begin
                data_d  = lfsr_q;
                valid_d = 1'b1;
                last_d  = (cnt_q == CNT_W'(1));
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = WAIT;
            end
            WAIT: if (out_ready) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = (cnt_q != '0) ? STEP : DONE;
                step_d  = (cnt_q != '0);
                ack_d   = (cnt_q != '0) ? 2'b00 : (id_q ? 2'b10 : 2'b01);
            end
            DONE: begin
                prio_d  = ~id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            seed_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            load_q  <= 1'b0;
            step_q  <= 1'b0;
            ack_q   <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            load_q  <= load_d;
            step_q  <= step_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end
    assign ack       = ack_q;
    assign lfsr_load = load_q;
    assign lfsr_seed = seed_q;
    assign lfsr_step = step_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_id    = id_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
endmodule
